// File: rtl/l1d_mem_responder.sv
// l1d_mem_responder
//   Memory-side responder for the L1 data cache request port. It takes one
//   request at a time from the cache and services it against a synchronous,
//   single-port word SRAM. The request can be a single-beat write, a single-beat
//   uncacheable read, or a four-beat wrapping line-fill read. Each read beat and
//   each write completion is reported to the cache by a one-cycle low pulse on
//   D_wait.
//
// Ports
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   D_rreq/D_wreq   read / write request, sampled only while idle
//   D_addr          byte address; word address = D_addr[MEM_AW+1:2]
//   D_write         write qualifier, must accompany D_wreq
//   D_in            write data, unshifted (low bits)
//   D_type          access size [1:0]: 00 byte, 01 half, else word
//   arlenone_i      1 = single-beat read, 0 = four-beat line fill
//   D_out           registered read beat data
//   D_wait          low for one cycle per completed beat or write
//   mem_*           SRAM chip select, output enable, active-low byte write
//                   enables, word address, write data, read data
module l1d_mem_responder #(
  parameter int MEM_AW    = 14,
  parameter int RD_LAT    = 1,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              D_rreq,
  input  logic              D_wreq,
  input  logic [31:0]       D_addr,
  input  logic              D_write,
  input  logic [31:0]       D_in,
  input  logic [2:0]        D_type,
  input  logic              arlenone_i,
  output logic [31:0]       D_out,
  output logic              D_wait,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic [3:0]        mem_web,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_di,
  input  logic [31:0]       mem_do
);

  localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);
  localparam logic [1:0] LAT_LAST  = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {IDLE, WRITE, WACK, RADDR, RLAT, RBEAT} state_t;

  state_t            state_reg, state_next;
  logic [MEM_AW-1:0] waddr_reg, waddr_next;
  logic [1:0]        boff_reg, boff_next;
  logic [31:0]       din_reg, din_next;
  logic [1:0]        type_reg, type_next;
  logic              single_reg, single_next;
  logic [1:0]        beat_reg, beat_next;
  logic [1:0]        lat_reg, lat_next;
  logic [31:0]       dout_reg, dout_next;

  // Address bits above the SRAM and the size MSB are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{D_addr[31:MEM_AW+2], D_type[2]};

  // Word address of the current beat. A line fill wraps within the
  // four-word line, so only the two low word-address bits advance.
  logic [MEM_AW-1:0] beat_addr;
  always_comb begin
    beat_addr = waddr_reg;
    if (!single_reg) begin
      beat_addr[1:0] = waddr_reg[1:0] + beat_reg;
    end
  end

  // Per-byte-lane write enable and write data. Narrow writes replicate the
  // datum across the word so each enabled lane already holds the right byte.
  logic [3:0]  lane_we;
  logic [31:0] lane_di;
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_we[gi] = (type_reg == 2'b00) ? (boff_reg == LANE) :
                         (type_reg == 2'b01) ? (boff_reg[1] == LANE[1]) :
                         1'b1;
    assign lane_di[gi*8 +: 8] = (type_reg == 2'b00) ? din_reg[7:0] :
                                (type_reg == 2'b01) ? din_reg[(gi%2)*8 +: 8] :
                                din_reg[gi*8 +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      waddr_reg  <= '0;
      boff_reg   <= '0;
      din_reg    <= '0;
      type_reg   <= '0;
      single_reg <= 1'b0;
      beat_reg   <= '0;
      lat_reg    <= '0;
      dout_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      waddr_reg  <= waddr_next;
      boff_reg   <= boff_next;
      din_reg    <= din_next;
      type_reg   <= type_next;
      single_reg <= single_next;
      beat_reg   <= beat_next;
      lat_reg    <= lat_next;
      dout_reg   <= dout_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    waddr_next  = waddr_reg;
    boff_next   = boff_reg;
    din_next    = din_reg;
    type_next   = type_reg;
    single_next = single_reg;
    beat_next   = beat_reg;
    lat_next    = lat_reg;
    dout_next   = dout_reg;
    D_wait      = 1'b1;
    mem_cs      = 1'b0;
    mem_oe      = 1'b0;
    mem_web     = 4'hf;
    mem_addr    = '0;
    mem_di      = '0;

    case (state_reg)
      IDLE: begin
        // A write request without D_write is not a write; it is dropped.
        if ((D_wreq && D_write) || D_rreq) begin
          waddr_next  = D_addr[MEM_AW+1:2];
          boff_next   = D_addr[1:0];
          din_next    = D_in;
          type_next   = D_type[1:0];
          single_next = arlenone_i;
          beat_next   = '0;
          state_next  = (D_wreq && D_write) ? WRITE : RADDR;
        end
      end
      WRITE: begin
        mem_cs     = 1'b1;
        mem_addr   = waddr_reg;
        mem_web    = ~lane_we;
        mem_di     = lane_di;
        state_next = WACK;
      end
      WACK: begin
        D_wait     = 1'b0;
        state_next = IDLE;
      end
      RADDR: begin
        mem_cs     = 1'b1;
        mem_oe     = 1'b1;
        mem_addr   = beat_addr;
        lat_next   = '0;
        state_next = RLAT;
      end
      RLAT: begin
        // Chip select is dropped so the SRAM is not re-read while waiting.
        mem_oe   = 1'b1;
        mem_addr = beat_addr;
        if (lat_reg == LAT_LAST) begin
          dout_next  = mem_do;
          state_next = RBEAT;
        end else begin
          lat_next = lat_reg + 2'd1;
        end
      end
      RBEAT: begin
        D_wait = 1'b0;
        if (!single_reg && (beat_reg != LAST_BEAT)) begin
          beat_next  = beat_reg + 2'd1;
          state_next = RADDR;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign D_out = dout_reg;

endmodule

// File: tb/tb_l1d_mem_responder.sv
// Testbench for l1d_mem_responder. Two instances are built, one with read
// latency 1 and one with latency 3, each with its own SRAM model. A
// transaction-level model computes, for every accepted request, the cycles at
// which D_wait must pulse, the read data, and the SRAM write pattern. The model
// uses byte-span arithmetic on a reference memory. One compare process per
// instance checks every cycle against that model.
module tb_l1d_mem_responder;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rreq [2];
  logic        wreq [2];
  logic        wr   [2];
  logic [31:0] addr [2];
  logic [31:0] din  [2];
  logic [2:0]  typ  [2];
  logic        one  [2];

  logic [31:0] ref_mem [2][256];
  logic [32:0] exp_low [longint];   // {is_read, data} at D_wait-low cycles
  logic [43:0] exp_wr  [longint];   // {word addr, web, di} at SRAM write cycles
  logic        h_wait  [longint];
  logic [31:0] h_dout  [longint];
  logic [3:0]  h_web   [longint];
  logic [7:0]  h_addr  [longint];
  logic [31:0] h_di    [longint];

  int n_pass = 0;
  int n_tot  = 0;

  function automatic longint key(input longint c, input int i);
    return c * 2 + longint'(i);
  endfunction

  function automatic logic [31:0] init_word(input int i, input int w);
    return (32'(w) * 32'h9E3779B1) ^ (32'(i) << 28) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    else n_pass++;
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int LAT = (gi == 0) ? 1 : 3;
    logic [31:0]   d_out;
    logic          d_wait;
    logic          m_cs, m_oe;
    logic [3:0]    m_web;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_di, m_do;
    logic [31:0]   sram    [0:255];
    logic [31:0]   rd_pipe [0:LAT-1];
    logic [31:0]   cur_dout;
    longint        k;

    l1d_mem_responder #(.MEM_AW(AW), .RD_LAT(LAT), .BURST_LEN(4)) dut (
      .clk(clk), .rst(rst),
      .D_rreq(rreq[gi]), .D_wreq(wreq[gi]), .D_addr(addr[gi]), .D_write(wr[gi]),
      .D_in(din[gi]), .D_type(typ[gi]), .arlenone_i(one[gi]),
      .D_out(d_out), .D_wait(d_wait),
      .mem_cs(m_cs), .mem_oe(m_oe), .mem_web(m_web), .mem_addr(m_addr),
      .mem_di(m_di), .mem_do(m_do)
    );

    initial for (int w = 0; w < 256; w++) sram[w] = init_word(gi, w);

    // Synchronous SRAM: read data appears LAT cycles after the address cycle.
    always @(posedge clk) begin
      if (m_cs && m_web != 4'hf) begin
        for (int b = 0; b < 4; b++)
          if (!m_web[b]) sram[m_addr][b*8 +: 8] = m_di[b*8 +: 8];
      end else if (m_cs && m_oe) begin
        rd_pipe[0] <= sram[m_addr];
      end
      for (int s = 1; s < LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
    assign m_do = rd_pipe[LAT-1];

    always @(negedge clk) begin
      k = key(cyc, gi);
      if (rst) begin
        cur_dout = 32'h0;
        chk($sformatf("reset_outputs i%0d c%0d", gi, cyc),
            {d_out, d_wait, m_cs, m_oe, m_web, m_addr, m_di},
            {32'h0, 1'b1, 1'b0, 1'b0, 4'hf, 8'h00, 32'h0});
      end else begin
        h_wait[k] = d_wait; h_dout[k] = d_out; h_web[k] = m_web;
        h_addr[k] = m_addr; h_di[k] = m_di;
        if (exp_low.exists(k)) begin
          chk($sformatf("wait_low i%0d c%0d", gi, cyc), d_wait, 1'b0);
          if (exp_low[k][32]) cur_dout = exp_low[k][31:0];
        end else begin
          chk($sformatf("wait_high i%0d c%0d", gi, cyc), d_wait, 1'b1);
        end
        chk($sformatf("d_out i%0d c%0d", gi, cyc), d_out, cur_dout);
        if (exp_wr.exists(k))
          chk($sformatf("sram_write i%0d c%0d", gi, cyc), {m_cs, m_web, m_addr, m_di},
              {1'b1, exp_wr[k][35:32], exp_wr[k][43:36], exp_wr[k][31:0]});
        else
          chk($sformatf("no_write i%0d c%0d", gi, cyc), m_web, 4'hf);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int i);
    rreq[i] = 1'b0; wreq[i] = 1'b0; wr[i] = 1'b0;
    addr[i] = 32'h0; din[i] = 32'h0; typ[i] = 3'h0; one[i] = 1'b0;
  endtask

  // Random request traffic while the block is busy; it must all be ignored.
  task automatic noise(input int i);
    rreq[i] = 1'($urandom); wreq[i] = 1'($urandom); wr[i] = 1'($urandom);
    addr[i] = $urandom; din[i] = $urandom; typ[i] = 3'($urandom); one[i] = 1'($urandom);
  endtask

  // Present a request in an idle cycle and record what the block must do.
  task automatic issue(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] t, input bit single, output longint t0, output int len);
    int lat, size, start, n;
    logic [3:0] web;
    logic [31:0] di;
    logic [7:0] wa, wk;
    lat = (i == 0) ? 1 : 3;
    t0 = cyc;
    wa = a[9:2];
    quiet(i);
    addr[i] = a; din[i] = d; typ[i] = t; one[i] = single;
    if (w) begin
      wreq[i] = 1'b1; wr[i] = 1'b1; rreq[i] = 1'($urandom);
      size = (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
      start = int'(a[1:0]) & ~(size - 1);
      web = 4'hf; di = 32'h0;
      for (int b = 0; b < 4; b++) begin
        di[b*8 +: 8] = d[(b % size)*8 +: 8];
        if (b >= start && b < start + size) begin
          web[b] = 1'b0;
          ref_mem[i][wa][b*8 +: 8] = d[(b % size)*8 +: 8];
        end
      end
      exp_wr[key(t0 + 1, i)] = {wa, web, di};
      exp_low[key(t0 + 2, i)] = {1'b0, 32'h0};
      len = 3;
    end else begin
      rreq[i] = 1'b1;
      n = single ? 1 : 4;
      for (int kb = 0; kb < n; kb++) begin
        wk = single ? wa : {wa[7:2], 2'(int'(wa[1:0]) + kb)};
        exp_low[key(t0 + (kb + 1) * (lat + 2), i)] = {1'b1, ref_mem[i][wk]};
      end
      len = n * (lat + 2) + 1;
    end
    $display("txn i%0d c%0d %s a=%h d=%h type=%0d single=%0b", i, t0,
             w ? "write" : "read ", a, d, t, single);
  endtask

  task automatic run(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] t, input bit single, input bit hold, output longint t0);
    int len;
    issue(i, w, a, d, t, single, t0, len);
    for (int c = 1; c < len; c++) begin
      step();
      if (!hold) noise(i);
    end
    step();
    quiet(i);
  endtask

  task automatic rand_txns(input int i, input int cnt);
    longint t0;
    logic [31:0] a;
    for (int n = 0; n < cnt; n++) begin
      a = $urandom;
      a[9:6] = 4'b0100;   // 16-word window so reads hit earlier writes
      run(i, 1'($urandom), a, $urandom, 3'($urandom), 1'($urandom), 1'($urandom), t0);
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    longint t0;
    int len;
    logic [31:0] vals [4];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
    for (int i = 0; i < 2; i++) begin
      quiet(i);
      for (int w = 0; w < 256; w++) ref_mem[i][w] = init_word(i, w);
    end
    repeat (3) step();
    rst = 1'b0;
    repeat (4) step();

    // Directed writes with hand-computed SRAM patterns.
    run(0, 1'b1, 32'h0000_0104, 32'hDEADBEEF, 3'b010, 1'b0, 1'b0, t0);
    chk("word_wr_addr", h_addr[key(t0 + 1, 0)], 8'h41);
    chk("word_wr_web", h_web[key(t0 + 1, 0)], 4'b0000);
    chk("word_wr_di", h_di[key(t0 + 1, 0)], 32'hDEADBEEF);
    chk("word_wr_ack", h_wait[key(t0 + 2, 0)], 1'b0);
    run(0, 1'b1, 32'h0000_0103, 32'h0000_00A5, 3'b000, 1'b0, 1'b0, t0);
    chk("byte_wr_web", h_web[key(t0 + 1, 0)], 4'b0111);
    chk("byte_wr_di", h_di[key(t0 + 1, 0)], 32'hA5A5A5A5);
    run(0, 1'b1, 32'h0000_0102, 32'h0000_1234, 3'b001, 1'b0, 1'b0, t0);
    chk("half_wr_web", h_web[key(t0 + 1, 0)], 4'b0011);
    chk("half_wr_di", h_di[key(t0 + 1, 0)], 32'h12341234);

    // Preload line 0x40..0x43 back to back, then fill it with D_rreq held.
    for (int w = 0; w < 4; w++)
      run(0, 1'b1, 32'h100 + 32'(w * 4), vals[w], 3'b010, 1'b0, 1'b0, t0);
    run(0, 1'b0, 32'h0000_0100, 32'h0, 3'b010, 1'b0, 1'b1, t0);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("fill_wait%0d", b), h_wait[key(t0 + 3 * (b + 1), 0)], 1'b0);
      chk($sformatf("fill_data%0d", b), h_dout[key(t0 + 3 * (b + 1), 0)], vals[b]);
    end
    chk("fill_gap", h_wait[key(t0 + 4, 0)], 1'b1);
    run(0, 1'b0, 32'h0000_0108, 32'h0, 3'b010, 1'b1, 1'b0, t0);
    chk("single_wait", h_wait[key(t0 + 3, 0)], 1'b0);
    chk("single_data", h_dout[key(t0 + 3, 0)], 32'h33);

    // Write request without D_write must be ignored.
    wreq[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h104; din[0] = 32'hFFFF_FFFF;
    repeat (3) step();
    quiet(0);
    step();

    rand_txns(0, 60);

    // Reset in cycle 5 of a burst, then confirm normal operation resumes.
    issue(0, 1'b0, 32'h0000_0124, 32'h0, 3'b010, 1'b0, t0, len);
    repeat (5) begin step(); noise(0); end
    rst = 1'b1;
    exp_low.delete();
    exp_wr.delete();
    quiet(0);
    repeat (2) step();
    rst = 1'b0;
    step();
    run(0, 1'b1, 32'h0000_0124, 32'hCAFEF00D, 3'b010, 1'b0, 1'b0, t0);
    run(0, 1'b0, 32'h0000_0120, 32'h0, 3'b010, 1'b0, 1'b0, t0);
    chk("post_rst_data", h_dout[key(t0 + 6, 0)], 32'hCAFEF00D);

    // Latency-3 instance: the single-beat pulse moves to cycle 5.
    run(1, 1'b1, 32'h0000_0108, 32'h33, 3'b010, 1'b0, 1'b0, t0);
    run(1, 1'b0, 32'h0000_0108, 32'h0, 3'b010, 1'b1, 1'b0, t0);
    chk("lat3_early", h_wait[key(t0 + 3, 1)], 1'b1);
    chk("lat3_wait", h_wait[key(t0 + 5, 1)], 1'b0);
    chk("lat3_data", h_dout[key(t0 + 5, 1)], 32'h33);
    rand_txns(1, 30);

    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/l1d_mem_responder.md
# l1d_mem_responder

Memory-side responder for the L1 data cache request port. Accepts the cache's single-beat write and read requests, including four-beat line-fill reads and single-beat uncacheable reads. Services each request against a synchronous single-port word SRAM. Returns read beats and write completion on the cache's `D_out`/`D_wait` handshake. Sits between the data cache and data memory in place of a bus master during standalone cache bring-up and verification.

## Interface
Parameters:
- `MEM_AW`, 14: SRAM word-address width; `mem_addr = addr[MEM_AW+1:2]`, higher address bits ignored (aliasing).
- `RD_LAT`, 1: SRAM read latency in cycles, legal 1..4.
- `BURST_LEN`, 4: beats per line fill; fixed, the block does not support other values.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `D_rreq` in 1: read request; may stay high for a whole burst.
- `D_wreq` in 1: write request.
- `D_addr` in 32: byte address.
- `D_write` in 1: write qualifier; must be 1 with `D_wreq`.
- `D_in` in 32: write data, unshifted, in the low bits.
- `D_type` in 3: access size; `[1:0]` 00 byte, 01 halfword, other values word; `[2]` ignored.
- `arlenone_i` in 1: 1 = single-beat read (uncacheable); 0 = 4-beat line fill.
- `D_out` out 32: read beat data, registered.
- `D_wait` out 1: 0 for exactly one cycle per completed beat or write; 1 otherwise.
- `mem_cs` out 1: SRAM chip select.
- `mem_oe` out 1: SRAM output enable.
- `mem_web` out 4: SRAM byte write enables, active-low.
- `mem_addr` out MEM_AW: SRAM word address.
- `mem_di` out 32: SRAM write data.
- `mem_do` in 32: SRAM read data, valid RD_LAT cycles after the address cycle.

## Operation
- FSM states: IDLE, WRITE, WACK, RADDR, RLAT, RBEAT.
- IDLE
  - `D_wait`=1, `mem_cs`=0, `mem_web`=4'hf.
  - Samples requests every cycle.
  - `D_wreq` has priority over `D_rreq`. `D_wreq` with `D_write`=0 is ignored and the block stays in IDLE.
  - On acceptance, latches `D_addr`, `D_in`, `D_type`, `arlenone_i`, and clears the beat counter (2 bits).
- Write acceptance: IDLE→WRITE.
- WRITE (one cycle): `mem_cs`=1, `mem_oe`=0, `mem_addr` = latched word address.
  - `mem_web`:
    - byte: all ones except bit `addr[1:0]` = 0.
    - half: `addr[1]` ? 4'b0011 : 4'b1100.
    - word: 4'b0000.
  - `mem_di`: byte `{4{d[7:0]}}`, half `{2{d[15:0]}}`, word `d`.
  - WRITE→WACK.
- WACK: `D_wait`=0 for one cycle, `D_out` unchanged. WACK→IDLE.
- Read acceptance: IDLE→RADDR.
  - Burst (`arlenone`=0): starting word = `addr[3:2]`. Beat k uses word `(addr[3:2]+k) mod 4` in the same line; the offset wraps within the 16-byte line.
  - Single (`arlenone`=1): one beat at `addr[31:2]`.
- RADDR: `mem_cs`=1, `mem_oe`=1, `mem_web`=4'hf, address of the current beat. RADDR→RLAT.
- RLAT: waits RD_LAT cycles, `mem_oe` held 1. On its last cycle, `D_out <= mem_do`. RLAT→RBEAT.
- RBEAT: `D_wait`=0, `D_out` holds the beat and keeps it until the next load.
  - If beats remain: counter+1, RBEAT→RADDR.
  - Otherwise: RBEAT→IDLE.
- Requests arriving in any state other than IDLE are ignored. A held `D_rreq` during a burst does not start a new burst. A new request is sampled only in IDLE.

## Timing
- Reset values: `D_out`=0, `D_wait`=1, `mem_cs`=0, `mem_oe`=0, `mem_web`=4'hf, `mem_addr`=0, `mem_di`=0, state IDLE, beat counter 0.
- Asserting `rst` mid-transaction aborts it immediately and all outputs return to their reset values. No partial write occurs unless the WRITE cycle already had a clock edge.
- Write latency: request accepted at cycle 0 → SRAM write at cycle 1 → `D_wait`=0 at cycle 2 → IDLE at cycle 3.
- Read latency: beat k (0-based) has `D_wait`=0 at cycle `(k+1)*(RD_LAT+2)`.
  - With RD_LAT=1, a 4-beat burst completes at cycle 12 and the block is in IDLE at cycle 13.
- Back-to-back: a request present in the first IDLE cycle after completion is accepted in that cycle.
- Simultaneous `D_rreq` and `D_wreq` in IDLE: the write is serviced; the read is serviced only if `D_rreq` is still high in the next IDLE cycle.

## Test plan
- Reset, then idle with no requests → `D_wait`=1, `mem_cs`=0, `mem_web`=4'hf, `D_out`=0 on every cycle.
- Word write: `D_wreq`=1, `D_write`=1, addr 0x0000_0104, type word, data 0xDEADBEEF → cycle 1 shows `mem_addr`=0x41, `mem_web`=0000, `mem_di`=0xDEADBEEF; cycle 2 `D_wait`=0.
- Byte write to addr 0x0000_0103, data 0x000000A5 → `mem_web`=0111, `mem_di`=0xA5A5A5A5. Half write to addr 0x0000_0102 → `mem_web`=0011.
- Line fill, RD_LAT=1, SRAM preloaded with words 0x40..0x43 = 0x11,0x22,0x33,0x44, `D_rreq` held high, addr 0x0000_0100 → `D_wait`=0 at cycles 3,6,9,12 with `D_out` = 0x11,0x22,0x33,0x44; state is IDLE at cycle 13.
- Single-beat read with `arlenone`=1, addr 0x0000_0108 → exactly one `D_wait`=0 pulse, at cycle 3, with `D_out` = word 0x42. Repeat with RD_LAT=3 → the pulse is at cycle 5.
- Assert `rst` at cycle 5 of a burst → all outputs at reset values the same cycle. After release, a new write completes normally and the SRAM holds no corrupt data.
